// File: rtl/ram.sv
// ram: single-port synchronous RAM with registered, read-first output and range-checked addressing
module ram #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int MEM_SIZE  = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout
);
  localparam int IW = MEM_SIZE > 1 ? $clog2(MEM_SIZE) : 1;
  logic [WORD_SIZE-1:0] mem [MEM_SIZE] = '{default: '0};
  logic [IW-1:0] idx;
  logic in_range;
  // 64-bit compare keeps every address bit and any MEM_SIZE value intact
  always_comb begin
    in_range = 64'(addr) < 64'(MEM_SIZE);
    idx = IW'(addr);
  end
  always_ff @(posedge clock)
    if (we && in_range) mem[idx] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) dout <= '0;
    else dout <= in_range ? mem[idx] : '0;
endmodule

// File: tb/tb_ram.sv
// tb_ram: directed and randomized checks of ram against an array model, 64-word configuration
module tb_ram;
  localparam int N = 64;
  logic clock = 0;
  logic reset = 1;
  logic we = 0;
  logic [17:0] addr = '0;
  logic [17:0] din = '0;
  logic [17:0] dout;
  logic [17:0] model [N];
  int tests = 0;
  int fails = 0;

  ram #(.ADDR_SIZE(18), .WORD_SIZE(18), .MEM_SIZE(N)) dut (
    .clock(clock), .reset(reset), .we(we), .addr(addr), .din(din), .dout(dout)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one clock of access; expected dout is the word held before this edge's write
  task automatic step(input string tag, input logic w, input logic [17:0] a, input logic [17:0] d);
    logic [17:0] exp;
    we = w; addr = a; din = d;
    @(posedge clock);
    #1;
    exp = !reset ? 18'h0 : (a < N) ? model[a] : 18'h0;
    if (w && a < N) model[a] = d;
    check(tag, dout, exp);
  endtask

  initial begin
    for (int i = 0; i < N; i++) model[i] = '0;
    #1 reset = 0;
    #1 check("async_reset_t0", dout, 18'h0);
    step("reset_hold0", 0, 18'd1, 18'h0);
    step("reset_hold1", 0, 18'd2, 18'h0);
    #2 reset = 1;
    for (int i = 0; i < N; i++) check("mem_zero", dut.mem[i], 18'h0);
    step("read_zero", 0, 18'd10, 18'h0);
    step("write5", 1, 18'd5, 18'h2A5A5);
    step("read5", 0, 18'd5, 18'h0);
    step("write3", 1, 18'd3, 18'h00011);
    step("read_first3", 1, 18'd3, 18'h3FFFF);
    step("read3_new", 0, 18'd3, 18'h0);
    step("oor_write64", 1, 18'd64, 18'h12345);
    check("oor_mem0", dut.mem[0], model[0]);
    step("oor_read64", 0, 18'd64, 18'h0);
    step("oor_high_write", 1, 18'h10005, 18'h0ABCD);
    step("alias_read5", 0, 18'd5, 18'h0);
    step("oor_max_read", 0, 18'h3FFFF, 18'h0);
    step("reload5", 0, 18'd5, 18'h0);
    check("dout_before_reset", dout, 18'h2A5A5);
    #3 reset = 0;
    #1 check("async_reset_mid", dout, 18'h0);
    step("write_in_reset", 1, 18'd7, 18'h15555);
    #2 reset = 1;
    step("after_reset5", 0, 18'd5, 18'h0);
    step("after_reset7", 0, 18'd7, 18'h0);
    check("mem5_kept", dut.mem[5], 18'h2A5A5);
    for (int i = 0; i < N; i++) step("b2b_write", 1, 18'(i), 18'(i) ^ 18'h3FFFF);
    for (int i = 0; i < N; i++) step("seq_read", 0, 18'(i), 18'h0);
    step("seq_read_tail", 0, 18'd0, 18'h0);
    for (int k = 0; k < 400; k++) begin
      logic [17:0] a;
      a = ($urandom_range(0, 9) == 0) ? 18'($urandom) : 18'($urandom_range(0, N + 15));
      step("random", 1'($urandom), a, 18'($urandom));
    end
    for (int i = 0; i < N; i++) check("final_mem", dut.mem[i], model[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
